// File: rtl/data_mem_responder.sv
// Byte-addressed, little-endian data memory with a fixed access latency,
// served over valid/ready request and response channels.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);
  localparam int                  WORDS   = 1 << (ADDR_WIDTH - 3);
  localparam logic [3:0]          LAT_M1  = 4'(LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] MEM_END = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;

  logic        write_q;
  logic [63:0] addr_q;
  logic [3:0]  size_q;
  logic [63:0] wdata_q;

  // Held as 64-bit words: every legal access is naturally aligned and
  // therefore never straddles two words.
  logic [63:0] mem [0:WORDS-1] = '{default: 64'h0};

  logic                  accept;
  logic                  do_access;
  logic                  a_write;
  logic [63:0]           a_addr;
  logic [63:0]           a_wdata;
  logic [3:0]            a_size;
  logic [ADDR_WIDTH-4:0] widx;
  logic [5:0]            bit_off;
  logic [63:0]           cur_word;
  logic [63:0]           size_mask;
  logic [63:0]           lane_mask;
  logic [63:0]           wr_word;
  logic [63:0]           rd_data;
  logic [ADDR_WIDTH:0]   end_sum;
  logic                  a_error;

  assign accept    = req_valid && req_ready;
  assign do_access = (accept && (LATENCY == 1)) || (state == WAIT && cnt == 4'd1);

  // With LATENCY=1 the access happens on the accept edge, before the
  // request has been latched, so the live request fields are used.
  always_comb begin
    if (state == IDLE) begin
      a_write = req_write;
      a_addr  = req_addr;
      a_size  = req_size;
      a_wdata = req_wdata;
    end else begin
      a_write = write_q;
      a_addr  = addr_q;
      a_size  = size_q;
      a_wdata = wdata_q;
    end
  end

  always_comb begin
    widx     = a_addr[ADDR_WIDTH-1:3];
    bit_off  = {a_addr[2:0], 3'b000};
    cur_word = mem[widx];
    case (a_size)
      4'd1:    size_mask = 64'h0000_0000_0000_00FF;
      4'd2:    size_mask = 64'h0000_0000_0000_FFFF;
      4'd4:    size_mask = 64'h0000_0000_FFFF_FFFF;
      4'd8:    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      default: size_mask = 64'h0;
    endcase
    lane_mask = size_mask << bit_off;
    wr_word   = (cur_word & ~lane_mask) | ((a_wdata & size_mask) << bit_off);
    rd_data   = (cur_word >> bit_off) & size_mask;
    end_sum   = {1'b0, a_addr[ADDR_WIDTH-1:0]} + (ADDR_WIDTH+1)'(a_size);
    a_error   = (size_mask == 64'h0)
             || (|(a_addr[3:0] & (a_size - 4'd1)))
             || (|a_addr[63:ADDR_WIDTH])
             || (end_sum > MEM_END);
  end

  always_ff @(posedge clk) begin
    if (!reset && do_access && a_write && !a_error)
      mem[widx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      size_q  <= req_size;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= LAT_M1;
      else if (state == WAIT)
        cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= 64'h0;
      resp_error <= 1'b0;
    end else if (do_access) begin
      resp_error <= a_error;
      resp_rdata <= (a_write || a_error) ? 64'h0 : rd_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed and random load/store traffic
// against a byte-array reference model, on LATENCY=2 and LATENCY=1 builds.
module tb_data_mem_responder;
  localparam int LAT0 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_write, resp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [3:0]  req_size;
  logic        req_ready, resp_valid, resp_error;
  logic [63:0] resp_rdata;

  logic        b_reset, b_req_valid, b_req_write, b_resp_ready;
  logic [63:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_size;
  logic        b_req_ready, b_resp_valid, b_resp_error;
  logic [63:0] b_resp_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [0:1][0:1023];

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [3:0]  size;
    logic [63:0] wdata;
    logic [63:0] exp;
    bit          exp_err;
  } op_t;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_size(b_req_size),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_error(b_resp_error)
  );

  // Reference: a plain byte array, with the legality rules applied directly.
  function automatic void model_access(input int u, input bit wr, input logic [63:0] addr,
                                       input logic [3:0] size, input logic [63:0] wdata,
                                       output logic [63:0] rd, output bit err);
    rd  = 64'h0;
    err = !(size == 4'd1 || size == 4'd2 || size == 4'd4 || size == 4'd8);
    if (!err && (addr % 64'(size)) != 0) err = 1'b1;
    if (!err && (addr >= 64'd1024 || addr + 64'(size) > 64'd1024)) err = 1'b1;
    if (err) return;
    for (int k = 0; k < int'(size); k++) begin
      if (wr) mdl[u][addr + 64'(k)] = wdata[8*k +: 8];
      else    rd[8*k +: 8] = mdl[u][addr + 64'(k)];
    end
  endfunction

  task automatic send_req(input bit wr, input logic [63:0] addr, input logic [3:0] size,
                          input logic [63:0] wdata, output bit tmo);
    int n = 0;
    tmo = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_wdata = wdata;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin tmo = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk); #1;
    // Scramble the fields: the DUT must rely only on what it latched.
    req_valid = 1'b0; req_write = ~wr; req_addr = {$urandom, $urandom};
    req_size = 4'($urandom); req_wdata = {$urandom, $urandom};
  endtask

  task automatic do_txn(input bit wr, input logic [63:0] addr, input logic [3:0] size,
                        input logic [63:0] wdata, input int stall,
                        output logic [63:0] rd, output bit err, output int lat, output bit tmo);
    rd = 64'h0; err = 1'b0; lat = 0;
    send_req(wr, addr, size, wdata, tmo);
    if (tmo) return;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) begin tmo = 1'b1; return; end
    rd = resp_rdata; err = resp_error;
    repeat (stall) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; b_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'h0 || resp_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_error);
    end
    total++;
    if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0 || b_resp_rdata !== 64'h0 || b_resp_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs_lat1: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
               b_req_ready, b_resp_valid, b_resp_rdata, b_resp_error);
    end
    reset = 1'b0; b_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    op_t ops[$];
    logic [63:0] rd, mrd;
    bit err, merr, tmo;
    int lat;
    ops.push_back('{1'b1, 64'h10, 4'd8, 64'h1122334455667788, 64'h0, 1'b0});
    ops.push_back('{1'b0, 64'h10, 4'd8, 64'h0, 64'h1122334455667788, 1'b0});
    ops.push_back('{1'b0, 64'h10, 4'd1, 64'h0, 64'h88, 1'b0});
    ops.push_back('{1'b0, 64'h12, 4'd2, 64'h0, 64'h5566, 1'b0});
    ops.push_back('{1'b0, 64'h14, 4'd4, 64'h0, 64'h11223344, 1'b0});
    ops.push_back('{1'b1, 64'h11, 4'd1, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1'b0});
    ops.push_back('{1'b0, 64'h10, 4'd8, 64'h0, 64'h112233445566AB88, 1'b0});
    foreach (ops[i]) begin
      do_txn(ops[i].wr, ops[i].addr, ops[i].size, ops[i].wdata, 0, rd, err, lat, tmo);
      model_access(0, ops[i].wr, ops[i].addr, ops[i].size, ops[i].wdata, mrd, merr);
      total++;
      if (tmo || rd !== ops[i].exp || err !== ops[i].exp_err) begin
        bad++;
        $display("FAIL store_load[%0d]: rdata=%h err=%b tmo=%b, want rdata=%h err=%b",
                 i, rd, err, tmo, ops[i].exp, ops[i].exp_err);
      end
      total++;
      if (lat != LAT0) begin
        bad++;
        $display("FAIL store_load_latency[%0d]: got %0d cycles, want %0d", i, lat, LAT0);
      end
    end
  endtask

  task automatic test_errors;
    op_t ops[$];
    logic [63:0] rd, mrd;
    bit err, merr, tmo;
    int lat;
    ops.push_back('{1'b1, 64'h12, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1});
    ops.push_back('{1'b1, 64'h20, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1});
    ops.push_back('{1'b1, 64'h400, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1});
    ops.push_back('{1'b0, 64'h8000_0000_0000_0010, 4'd8, 64'h0, 64'h0, 1'b1});
    ops.push_back('{1'b0, 64'h3FC, 4'd8, 64'h0, 64'h0, 1'b1});
    ops.push_back('{1'b0, 64'h10, 4'd0, 64'h0, 64'h0, 1'b1});
    ops.push_back('{1'b1, 64'h3F8, 4'd8, 64'hCAFE_F00D_1234_5678, 64'h0, 1'b0});
    ops.push_back('{1'b0, 64'h3F8, 4'd8, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0});
    ops.push_back('{1'b0, 64'h10, 4'd8, 64'h0, 64'h112233445566AB88, 1'b0});
    foreach (ops[i]) begin
      do_txn(ops[i].wr, ops[i].addr, ops[i].size, ops[i].wdata, 1, rd, err, lat, tmo);
      model_access(0, ops[i].wr, ops[i].addr, ops[i].size, ops[i].wdata, mrd, merr);
      total++;
      if (tmo || rd !== ops[i].exp || err !== ops[i].exp_err) begin
        bad++;
        $display("FAIL errors[%0d]: rdata=%h err=%b tmo=%b, want rdata=%h err=%b",
                 i, rd, err, tmo, ops[i].exp, ops[i].exp_err);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] mrd;
    bit merr, tmo;
    int n = 0;
    model_access(0, 1'b0, 64'h10, 4'd8, 64'h0, mrd, merr);
    send_req(1'b0, 64'h10, 4'd8, 64'h0, tmo);
    while (!tmo && !resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    total++;
    if (tmo || !resp_valid) begin
      bad++;
      $display("FAIL backpressure_resp: no response seen (tmo=%b valid=%b), want valid=1", tmo, resp_valid);
      return;
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== mrd || resp_error !== 1'b0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold[%0d]: valid=%b rdata=%h err=%b ready=%b, want 1 %h 0 0",
                 c, resp_valid, resp_rdata, resp_error, req_ready, mrd);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_release: valid=%b ready=%b, want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [63:0] rd, mrd;
    bit err, merr, tmo;
    int lat;
    send_req(1'b1, 64'h30, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, tmo);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'h0 || resp_error !== 1'b0) begin
        bad++;
        $display("FAIL reset_in_wait[%0d]: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                 c, req_ready, resp_valid, resp_rdata, resp_error);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    model_access(0, 1'b0, 64'h30, 4'd8, 64'h0, mrd, merr);
    do_txn(1'b0, 64'h30, 4'd8, 64'h0, 0, rd, err, lat, tmo);
    total++;
    if (tmo || rd !== mrd || err !== 1'b0 || mrd !== 64'h0) begin
      bad++;
      $display("FAIL reset_drops_store: rdata=%h err=%b tmo=%b, want rdata=0 err=0", rd, err, tmo);
    end
  endtask

  task automatic test_random;
    logic [63:0] rd, mrd, addr, wdata;
    logic [3:0] size;
    bit wr, err, merr, tmo;
    int lat, sel;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 15);
      size = (sel < 3) ? 4'd1 : (sel < 6) ? 4'd2 : (sel < 9) ? 4'd4 : (sel < 14) ? 4'd8 :
             (sel == 14) ? 4'd3 : 4'd0;
      addr = 64'($urandom_range(0, 1023));
      if ($urandom_range(0, 9) != 0 && sel < 14) addr = addr & ~(64'(size) - 64'd1);
      if ($urandom_range(0, 19) == 0) addr = addr | (64'd1 << $urandom_range(10, 63));
      wr = ($urandom_range(0, 1) == 1);
      wdata = {$urandom, $urandom};
      model_access(0, wr, addr, size, wdata, mrd, merr);
      do_txn(wr, addr, size, wdata, $urandom_range(0, 3), rd, err, lat, tmo);
      total++;
      if (tmo || rd !== mrd || err !== merr || lat != LAT0) begin
        bad++;
        $display("FAIL random[%0d] wr=%b addr=%h size=%0d: rdata=%h err=%b lat=%0d tmo=%b, want rdata=%h err=%b lat=%0d",
                 i, wr, addr, size, rd, err, lat, tmo, mrd, merr, LAT0);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] mrd;
    bit merr, was_ready;
    int naccept = 0;
    int last_acc = 0;
    b_resp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 64'h100;
    b_req_size = 4'd8; b_req_wdata = {$urandom, $urandom};
    for (int e = 0; e < 16; e++) begin
      was_ready = b_req_ready;
      @(posedge clk); #1;
      if (was_ready) begin
        model_access(1, b_req_write, b_req_addr, b_req_size, b_req_wdata, mrd, merr);
        total++;
        if (b_resp_valid !== 1'b1 || b_resp_rdata !== mrd || b_resp_error !== merr) begin
          bad++;
          $display("FAIL b2b_resp[%0d]: valid=%b rdata=%h err=%b, want 1 %h %b",
                   naccept, b_resp_valid, b_resp_rdata, b_resp_error, mrd, merr);
        end
        if (naccept > 0) begin
          total++;
          if (e - last_acc != 2) begin
            bad++;
            $display("FAIL b2b_interval[%0d]: got %0d cycles, want 2", naccept, e - last_acc);
          end
        end
        last_acc = e;
        naccept++;
        b_req_write = (naccept % 2 == 0);
        b_req_addr  = 64'h100 + 64'(8 * (naccept / 2));
        b_req_wdata = {$urandom, $urandom};
      end else begin
        total++;
        if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_idle[%0d]: valid=%b ready=%b, want 0 1", e, b_resp_valid, b_req_ready);
        end
      end
    end
    b_req_valid = 1'b0;
    total++;
    if (naccept != 8) begin
      bad++;
      $display("FAIL b2b_accepts: got %0d, want 8", naccept);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int u = 0; u < 2; u++)
      for (int a = 0; a < 1024; a++) mdl[u][a] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 64'h0;
    req_size = 4'd0; req_wdata = 64'h0; resp_ready = 1'b0;
    b_reset = 1'b1; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 64'h0;
    b_req_size = 4'd0; b_req_wdata = 64'h0; b_resp_ready = 1'b0;
    test_reset;
    test_store_load;
    test_errors;
    test_backpressure;
    test_reset_in_wait;
    test_random;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that serves load/store requests from the pipelined CPU's memory stage over a valid/ready request channel and a valid/ready response channel. It stores a byte-addressed, little-endian array and supports transfers of 1, 2, 4 or 8 bytes, matching the CPU's `xfer_size` encoding. A configurable access latency lets the CPU's stall logic be exercised against a slow memory. It replaces the zero-latency data memory behind the memory stage and sits between that stage and write-back.

## Interface
Parameters:
- ADDR_WIDTH, 10, log2 of storage size in bytes (default 1024 bytes).
- LATENCY, 2, cycles from request accept to response valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_size  in  4  transfer size in bytes; legal values 1, 2, 4, 8.
- req_wdata  in  64  store data; the low req_size bytes are used.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  64  load data, zero-extended; 0 for stores and errors.
- resp_error  out  1  request was illegal (see Operation).

## Operation
- Three-state FSM: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write, addr, size and wdata, then load the counter with LATENCY-1. If LATENCY=1, go directly to RESP; otherwise go to WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle. When it reaches 0, perform the access and go to RESP.
- Access (the transition into RESP):
  - Error check first. resp_error=1 if any of the following holds:
    - size is not in {1,2,4,8};
    - addr mod size != 0 (misaligned);
    - addr+size > 2^ADDR_WIDTH, including any set bit in addr[63:ADDR_WIDTH].
  - On error: storage is not modified and resp_rdata=0.
  - Store: byte k of the latched wdata (k = 0..size-1) is written to mem[addr+k]. resp_rdata=0.
  - Load: resp_rdata[8k+7:8k] = mem[addr+k] for k < size. Upper bytes are 0.
- RESP: resp_valid=1 and resp_rdata/resp_error are held stable. On resp_ready=1, go to IDLE.
- Storage is not cleared by reset. Contents are initialised to 0 at time zero only.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, counter=0.
- Reset asserted in WAIT: the pending request is dropped and no store is committed. Reset asserted in RESP: the response is dropped.
- Request accepted at edge N → resp_valid=1 during the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after accept.
- Stores become visible to a following load once their RESP is entered.
- req_ready is 0 from the edge after accept until the cycle after the response handshake. Minimum issue interval is LATENCY+1 cycles.
- resp_ready=1 on the first RESP cycle → IDLE on the next edge; a new request can be accepted in that IDLE cycle.
- resp_ready=0 holds RESP indefinitely, and outputs must not change.
- Request fields are sampled only at accept; later changes are ignored.
- req_valid while req_ready=0 is ignored, and the requester must hold it.

## Test plan
- Store 8 bytes 0x1122334455667788 at addr 0x10, then load 8 bytes at 0x10 → resp_rdata=0x1122334455667788 with resp_error=0. resp_valid rises exactly LATENCY cycles after each accept.
- Load size 1 at 0x10 → 0x88; size 2 at 0x12 → 0x5566; size 4 at 0x14 → 0x11223344. Then store size 1 of 0xAB at 0x11 and load 8 at 0x10 → 0x112233445566AB88.
- Misaligned store size 4 at 0x12, size 3 at 0x20, and addr 0x400 at default ADDR_WIDTH → each gives resp_error=1 and resp_rdata=0. Loading 0x10 afterwards → unchanged data.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid stays 1, data stays stable, req_ready stays 0. Then raise resp_ready → IDLE on the next edge.
- Accept a store of 0xFF.. at 0x30, then assert reset while in WAIT. After reset, load 0x30 → 0, and all outputs show reset values during reset.
- LATENCY=1 build: back-to-back requests with resp_ready tied 1 → one accept every 2 cycles, and each response arrives the cycle after its accept.
